// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit.
//   - op_e    : operation encodings as driven on the unit's op port
//   - state_e : control FSM states
//   - mode_e  : datapath mode selected for one iteration step
//   - twos_neg: two's-complement negate on a wide carrier vector. Callers
//               zero-extend their WIDTH-bit (or 2*WIDTH-bit) value and keep
//               the low bits. The low bits of a negation depend only on the
//               low bits of the input, so truncation gives the correct
//               narrower result.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    // Carrier width for twos_neg. It must be wider than 2*WIDTH of any
    // instance, so the unit supports WIDTH up to 126.
    localparam int NEG_MAX_W = 256;

    function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] v);
        return ~v + NEG_MAX_W'(1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   One combinational radix-2 iteration, shared by multiply and divide.
//
//   Multiply (shift-add, LSB first):
//     The accumulator is the pair {part_hi, part_lo}. in_bit is the current
//     multiplier LSB. When it is set, the multiplicand (operand) is added to
//     part_hi. The sum is then shifted right by one. res_bit is the product
//     bit that the caller shifts into the top of part_lo.
//
//   Divide (restoring, MSB first):
//     part_hi is the partial remainder. in_bit is the next dividend bit. The
//     unit forms the shifted remainder and subtracts the divisor (operand)
//     when that does not underflow. res_bit is the quotient bit that the
//     caller shifts into the bottom of part_lo.
//
// Ports:
//   mode     in   MODE_MUL / MODE_DIV
//   part_hi  in   WIDTH  accumulator high half / partial remainder
//   in_bit   in   1      multiplier LSB / next dividend bit
//   operand  in   WIDTH  multiplicand / divisor (magnitude)
//   next_hi  out  WIDTH  updated high half / partial remainder
//   res_bit  out  1      product bit retired / quotient bit
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mode_e             mode,
    input  logic [WIDTH-1:0]  part_hi,
    input  logic              in_bit,
    input  logic [WIDTH-1:0]  operand,
    output logic [WIDTH-1:0]  next_hi,
    output logic              res_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_hi = part_hi;
        res_bit = 1'b0;

        sum     = {1'b0, part_hi} + (in_bit ? {1'b0, operand} : '0);
        shifted = {part_hi, in_bit};

        if (mode == MODE_DIV) begin
            // A remainder below the divisor fits in WIDTH bits. The
            // difference taken modulo 2^WIDTH is therefore exact whenever
            // the trial subtraction succeeds.
            if (shifted >= {1'b0, operand}) begin
                next_hi = shifted[WIDTH-1:0] - operand;
                res_bit = 1'b1;
            end else begin
                next_hi = shifted[WIDTH-1:0];
                res_bit = 1'b0;
            end
        end else begin
            next_hi = sum[WIDTH:1];
            res_bit = sum[0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit beside the EX-stage ALU. It owns the
//   architectural HI/LO registers.
//   The unit works on operand magnitudes and fixes up signs when it writes
//   the result:
//     MULT/MULTU : {HI,LO} = a * b   (signed product negated when signs differ)
//     DIV/DIVU   : LO = a / b, HI = a % b   (quotient negated when signs
//                  differ, remainder takes the dividend's sign)
//     b == 0     : LO = all ones, HI = a
//   A start accepted at edge k keeps busy high from k to k+WIDTH. HI/LO are
//   written at edge k+WIDTH, and done pulses for the following cycle.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous, active-high
//   start   in   launch op on a/b (accepted in IDLE or DONE, not with cancel)
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a       in   WIDTH  multiplicand / dividend
//   b       in   WIDTH  multiplier / divisor
//   cancel  in   abort an in-flight operation (pipeline flush)
//   mthi    in   write wdata to HI (ignored while running)
//   mtlo    in   write wdata to LO (ignored while running)
//   wdata   in   WIDTH  MTHI/MTLO data
//   busy    out  operation in flight
//   done    out  one-cycle pulse: HI/LO just updated with a result
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
//
// WIDTH must be even, at least 4 and at most 126.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNTW = $clog2(WIDTH + 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e           state, state_d;
    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] part_hi;
    logic [WIDTH-1:0] part_lo;
    logic [WIDTH-1:0] operand;
    mode_e            mode_r;
    logic             neg_q_r;   // negate quotient / product at commit
    logic             neg_r_r;   // negate remainder at commit
    logic             div0_r;    // divisor was zero

    // ------------------------------------------------------------------
    // Start-side decode and operand magnitudes
    // ------------------------------------------------------------------
    op_e              op_sel;
    logic             is_div_in;
    logic             is_signed_in;
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             start_ok;
    logic             last_iter;

    logic [NEG_MAX_W-1:0] a_neg_x;
    logic [NEG_MAX_W-1:0] b_neg_x;

    assign op_sel       = op_e'(op);
    assign is_div_in    = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    assign is_signed_in = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    assign a_neg_in     = is_signed_in && a[WIDTH-1];
    assign b_neg_in     = is_signed_in && b[WIDTH-1];

    assign a_neg_x = twos_neg(NEG_MAX_W'(a));
    assign b_neg_x = twos_neg(NEG_MAX_W'(b));

    // The magnitude of MIN is MIN read as unsigned, so MIN / -1 needs no
    // special handling.
    assign abs_a = a_neg_in ? a_neg_x[WIDTH-1:0] : a;
    assign abs_b = b_neg_in ? b_neg_x[WIDTH-1:0] : b;

    // cancel beats start, and start is ignored while running.
    assign start_ok  = start && !cancel && (state != S_RUN);
    assign last_iter = (state == S_RUN) && !cancel && (count == CNTW'(1));

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    logic             step_in_bit;
    logic [WIDTH-1:0] step_hi;
    logic             step_bit;
    logic [WIDTH-1:0] lo_shift;

    // Multiply consumes the multiplier LSB-first from part_lo. Divide
    // consumes the dividend MSB-first. Each step retires one result bit
    // into the opposite end of part_lo.
    assign step_in_bit = (mode_r == MODE_DIV) ? part_lo[WIDTH-1] : part_lo[0];
    assign lo_shift    = (mode_r == MODE_DIV) ? {part_lo[WIDTH-2:0], step_bit}
                                              : {step_bit, part_lo[WIDTH-1:1]};

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode    (mode_r),
        .part_hi (part_hi),
        .in_bit  (step_in_bit),
        .operand (operand),
        .next_hi (step_hi),
        .res_bit (step_bit)
    );

    // ------------------------------------------------------------------
    // Sign fix-up of the final iteration's result
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   prod;
    logic [NEG_MAX_W-1:0] prod_neg_x;
    logic [NEG_MAX_W-1:0] quo_neg_x;
    logic [NEG_MAX_W-1:0] rem_neg_x;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    assign prod       = {step_hi, lo_shift};
    assign prod_neg_x = twos_neg(NEG_MAX_W'(prod));
    assign quo_neg_x  = twos_neg(NEG_MAX_W'(lo_shift));
    assign rem_neg_x  = twos_neg(NEG_MAX_W'(step_hi));

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (mode_r == MODE_DIV) begin
            // Dividing by zero leaves the dividend magnitude as the
            // remainder. The dividend-sign fix-up then restores the
            // original a in HI.
            res_lo = div0_r  ? '1 : (neg_q_r ? quo_neg_x[WIDTH-1:0] : lo_shift);
            res_hi = neg_r_r ? rem_neg_x[WIDTH-1:0] : step_hi;
        end else begin
            res_lo = neg_q_r ? prod_neg_x[WIDTH-1:0]       : prod[WIDTH-1:0];
            res_hi = neg_q_r ? prod_neg_x[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        end
    end

    // Only the low bits of each wide negate carrier are meaningful.
    logic unused_neg_bits;
    assign unused_neg_bits = ^{a_neg_x[NEG_MAX_W-1:WIDTH],
                               b_neg_x[NEG_MAX_W-1:WIDTH],
                               prod_neg_x[NEG_MAX_W-1:2*WIDTH],
                               quo_neg_x[NEG_MAX_W-1:WIDTH],
                               rem_neg_x[NEG_MAX_W-1:WIDTH]};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (start_ok) state_d = S_RUN;
            end
            S_RUN: begin
                if (cancel)                      state_d = S_IDLE;
                else if (count == CNTW'(1))      state_d = S_DONE;
            end
            S_DONE: begin
                state_d = start_ok ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // ------------------------------------------------------------------
    // Datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            part_hi <= '0;
            part_lo <= '0;
            operand <= '0;
            mode_r  <= MODE_MUL;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            div0_r  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here updates
            // from pre-edge values regardless of statement order.
            if (start_ok) begin
                count   <= CNTW'(WIDTH);
                part_hi <= '0;
                part_lo <= is_div_in ? abs_a : abs_b;
                operand <= is_div_in ? abs_b : abs_a;
                mode_r  <= is_div_in ? MODE_DIV : MODE_MUL;
                neg_q_r <= a_neg_in ^ b_neg_in;
                neg_r_r <= a_neg_in;
                div0_r  <= (b == '0);
            end else if (state == S_RUN) begin
                if (cancel) begin
                    count <= '0;
                end else begin
                    count   <= count - CNTW'(1);
                    part_hi <= step_hi;
                    part_lo <= lo_shift;
                end
            end

            // Moves to HI/LO only happen outside RUN, and the result
            // commit only happens in RUN, so the two never collide.
            if (last_iter) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state != S_RUN) begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed bench for muldiv_unit with WIDTH=32. Inputs are driven and
//   outputs sampled 1 time unit after each rising edge. Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches an operation. The edge consumed here is the start edge.
    task automatic start_op(input op_e o, input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    // Counts edges from the current sample until done, with a bounded wait.
    // busy_cycles counts samples with busy high, including the current one.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) busy_cycles++;
        end
    endtask

    task automatic do_op(input string tag, input op_e o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo);
        int lat;
        int bc;
        start_op(o, av, bv);
        wait_done(lat, bc);
        check({tag, "_latency"}, 32'(lat), 32'd32);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd32);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  lat;
        int  bc;
        logic saw_done;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        // Test 1: unsigned multiply
        do_op("multu_ffff_x2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);

        // Test 2: signed multiply and divide
        do_op("mult_m3_x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("div_m7_d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Test 3: divide boundary cases
        do_op("divu_7_d0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        do_op("div_min_dm1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        do_op("div_m9_d0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

        // A start pulsed during RUN is ignored and does not extend busy.
        start_op(OP_MULTU, 32'd3, 32'd5);
        repeat (6) tick();
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd9;
        b     = 32'd3;
        tick();
        start = 1'b0;
        wait_done(lat, bc);
        check("ignored_start_latency", 32'(lat + 7), 32'd32);
        check("ignored_start_lo", lo, 32'd15);
        check("ignored_start_hi", hi, 32'd0);
        tick();
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Test 4: MTLO in IDLE, MTHI ignored in RUN, cancel
        mtlo  = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        mtlo = 1'b0;
        check("mtlo_idle", lo, 32'h0000_1234);

        start_op(OP_MULTU, 32'd3, 32'd5);
        repeat (4) tick();
        mthi  = 1'b1;
        wdata = 32'h0000_BEEF;
        tick();
        mthi = 1'b0;
        check("mthi_in_run_ignored", hi, 32'h0);
        repeat (4) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_done", 32'(done), 32'd0);
        check("cancel_lo_kept", lo, 32'h0000_1234);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("cancel_no_done", 32'(saw_done), 32'd0);
        check("cancel_lo_still", lo, 32'h0000_1234);

        // cancel in the same cycle as start wins
        start  = 1'b1;
        cancel = 1'b1;
        op     = OP_MULTU;
        a      = 32'd2;
        b      = 32'd2;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_beats_start", 32'(busy), 32'd0);

        // MTHI and MTLO together both write.
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hA5A5_5A5A;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_mtlo_hi", hi, 32'hA5A5_5A5A);
        check("mthi_mtlo_lo", lo, 32'hA5A5_5A5A);

        // Test 5: back-to-back. The second start and an MTHI share the
        // DONE edge of the first operation.
        start_op(OP_MULTU, 32'd6, 32'd7);
        wait_done(lat, bc);
        check("b2b_first_latency", 32'(lat), 32'd32);
        check("b2b_first_lo", lo, 32'd42);
        check("b2b_first_hi", hi, 32'd0);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        mthi  = 1'b1;
        wdata = 32'h0000_0055;
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        check("b2b_no_gap_busy", 32'(busy), 32'd1);
        check("b2b_mthi_with_start", hi, 32'h0000_0055);
        wait_done(lat, bc);
        check("b2b_second_latency", 32'(lat), 32'd32);
        check("b2b_second_busy_cycles", 32'(bc), 32'd32);
        check("b2b_second_lo", lo, 32'd14);
        check("b2b_second_hi", hi, 32'd2);
        tick();

        // Test 6: asynchronous reset mid-RUN
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_hi", hi, 32'h0);
        check("async_rst_lo", lo, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        do_op("after_rst_multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
